// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point adder.
// Packages cannot take parameters, so everything that depends on the
// exponent/mantissa widths is a constant function of those widths that the
// user module evaluates into its own localparams.
//   fp_class_e     : operand classification (flushed denormals count as ZERO)
//   FLAG_*         : bit positions inside the 4-bit flags word
//   fp_bias        : exponent bias for a given exponent width
//   fp_max_exp     : all-ones exponent (inf/NaN encoding)
//   fp_qnan/fp_inf : canonical quiet NaN and signed infinity encodings
package fp_pkg;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  localparam int FLAG_W         = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_max_exp(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // {0, all-ones exponent, 1 then zeros}
  function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

  function automatic logic [127:0] fp_inf(input logic s, input int exp_w, input int man_w);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[exp_w + man_w] = s;
    return v;
  endfunction

endpackage

// File: rtl/fp_add_pipe_normalize.sv
// Leading-zero count and left shift of the stage-3 magnitude.
//   value   : unnormalised magnitude
//   shifted : value shifted left until its MSB is set (zero stays zero)
//   lzc     : number of leading zeros (WID when value is zero)
module fp_normalize #(
  parameter int WID = 27,
  parameter int LZW = $clog2(WID + 1)
) (
  input  logic [WID-1:0] value,
  output logic [WID-1:0] shifted,
  output logic [LZW-1:0] lzc
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    lzc = LZW'(WID);
    for (int i = 0; i < WID; i++) begin
      if (value[i]) lzc = LZW'(WID - 1 - i);
    end
  end

  assign shifted = value << lzc;

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage floating-point adder/subtractor, round-to-nearest-even.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready = pipeline may advance)
//   a, b, sub           : operands {sign, exp, frac}; sub=1 computes a-b
//   out_valid/out_ready : result handshake
//   out, flags          : result and {invalid, overflow, underflow, inexact}
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       a,
  input  logic [EXP_W+MAN_W:0]       b,
  input  logic                       sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       out,
  output logic [FLAG_W-1:0]          flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 4;            // {hidden, frac, guard, round, sticky}
  localparam int SW  = MAN_W + 5;            // adder width incl. carry
  localparam int LZW = $clog2(MW + 1);
  localparam int EW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;  // signed exponent
  localparam logic [W-1:0]         QNAN    = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0]         POS_INF = W'(fp_inf(1'b0, EXP_W, MAN_W));
  localparam logic [W-1:0]         NEG_INF = W'(fp_inf(1'b1, EXP_W, MAN_W));
  localparam logic signed [EW-1:0] MAX_E   = EW'(fp_max_exp(EXP_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return ZERO;
    if (&e) return (f != '0) ? NAN : INF;
    return NORM;
  endfunction

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- stage 1: unpack, specials, swap, align ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, e_hi, e_lo, d;
  logic [MAN_W-1:0] fa, fb, f_hi, f_lo;
  fp_class_e        ca, cb;
  logic             a_big, s_hi, lost, spec_c;
  logic [MW-1:0]    m_hi, m_lo_full, m_lo;
  logic [W-1:0]     spec_out_c;
  logic [3:0]       spec_fl_c;

  assign {sa, ea, fa} = a;
  assign sb = b[W-1] ^ sub;
  assign eb = b[W-2:MAN_W];
  assign fb = b[MAN_W-1:0];
  assign ca = classify(ea, fa);
  assign cb = classify(eb, fb);

  always_comb begin
    spec_c     = 1'b1;
    spec_out_c = '0;
    spec_fl_c  = '0;
    if (ca == NAN || cb == NAN || (ca == INF && cb == INF && sa != sb)) begin
      spec_out_c = QNAN;
      spec_fl_c[FLAG_INVALID] = 1'b1;
    end else if (ca == INF) spec_out_c = sa ? NEG_INF : POS_INF;
    else if (cb == INF)     spec_out_c = sb ? NEG_INF : POS_INF;
    else if (ca == ZERO && cb == ZERO) spec_out_c = {sa & sb, {(W-1){1'b0}}};
    else if (ca == ZERO)    spec_out_c = {sb, eb, fb};
    else if (cb == ZERO)    spec_out_c = {sa, ea, fa};
    else                    spec_c = 1'b0;
  end

  assign a_big     = {ea, fa} >= {eb, fb};
  assign s_hi      = a_big ? sa : sb;
  assign e_hi      = a_big ? ea : eb;
  assign e_lo      = a_big ? eb : ea;
  assign f_hi      = a_big ? fa : fb;
  assign f_lo      = a_big ? fb : fa;
  assign d         = e_hi - e_lo;
  assign m_hi      = {1'b1, f_hi, 3'b000};
  assign m_lo_full = {1'b1, f_lo, 3'b000};
  // Shifts wider than the field zero the value and mark every bit lost, so
  // very large D naturally leaves only sticky set.
  assign lost      = |(m_lo_full & ~({MW{1'b1}} << d));
  assign m_lo      = (m_lo_full >> d) | MW'(lost);

  logic             v1, sp1, s1, esub1;
  logic [W-1:0]     spo1;
  logic [3:0]       spf1;
  logic [EXP_W-1:0] e1;
  logic [MW-1:0]    m1, m2;

  // ---------------- stage 2: magnitude add/subtract ----------------
  logic [SW-1:0]    sum_c;
  assign sum_c = esub1 ? ({1'b0, m1} - {1'b0, m2}) : ({1'b0, m1} + {1'b0, m2});

  logic             v2, sp2, s2;
  logic [W-1:0]     spo2;
  logic [3:0]       spf2;
  logic [EXP_W-1:0] e2;
  logic [SW-1:0]    sum2;

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [MW-1:0]          nrm, n;
  logic [LZW-1:0]         lzc;
  logic                   carry, up, inexact;
  logic signed [EW-1:0]   e_n, e_r;
  logic [MAN_W+1:0]       mr;
  logic [MAN_W-1:0]       frac;
  logic [W-1:0]           res_c;
  logic [3:0]             fl_c;

  fp_normalize #(.WID(MW), .LZW(LZW)) u_norm (
    .value  (sum2[MW-1:0]),
    .shifted(nrm),
    .lzc    (lzc)
  );

  assign carry   = sum2[SW-1];
  // On carry-out the bit shifted off the bottom folds into sticky.
  assign n       = carry ? {sum2[SW-1:2], sum2[1] | sum2[0]} : nrm;
  assign e_n     = carry ? EW'(e2) + EW'(1) : EW'(e2) - EW'(lzc);
  assign up      = n[2] & (n[1] | n[0] | n[3]);
  assign inexact = |n[2:0];
  assign mr      = {1'b0, n[MW-1:3]} + (MAN_W+2)'(up);
  assign e_r     = mr[MAN_W+1] ? e_n + EW'(1) : e_n;
  assign frac    = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];

  always_comb begin
    res_c = '0;
    fl_c  = '0;
    if (sp2) begin
      res_c = spo2;
      fl_c  = spf2;
    end else if (sum2 == '0) begin
      res_c = '0;
    end else if (e_n[EW-1] || e_n == '0) begin
      res_c = {s2, {(W-1){1'b0}}};
      fl_c[FLAG_UNDERFLOW] = 1'b1;
      fl_c[FLAG_INEXACT]   = 1'b1;
    end else if (e_r >= MAX_E) begin
      res_c = s2 ? NEG_INF : POS_INF;
      fl_c[FLAG_OVERFLOW] = 1'b1;
      fl_c[FLAG_INEXACT]  = 1'b1;
    end else begin
      res_c = {s2, e_r[EXP_W-1:0], frac};
      fl_c[FLAG_INEXACT] = inexact;
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; sp1 <= 1'b0; s1 <= 1'b0; esub1 <= 1'b0;
      spo1 <= '0; spf1 <= '0; e1 <= '0; m1 <= '0; m2 <= '0;
      v2 <= 1'b0; sp2 <= 1'b0; s2 <= 1'b0;
      spo2 <= '0; spf2 <= '0; e2 <= '0; sum2 <= '0;
      out_valid <= 1'b0; out <= '0; flags <= '0;
    end else if (advance) begin
      v1    <= in_valid;
      sp1   <= spec_c;
      spo1  <= spec_out_c;
      spf1  <= spec_fl_c;
      s1    <= s_hi;
      esub1 <= sa ^ sb;
      e1    <= e_hi;
      m1    <= m_hi;
      m2    <= m_lo;
      v2    <= v1;
      sp2   <= sp1;
      spo2  <= spo1;
      spf2  <= spf1;
      s2    <= s1;
      e2    <= e1;
      sum2  <= sum_c;
      out_valid <= v2;
      out       <= res_c;
      flags     <= fl_c;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [31:0] a = '0, b = '0, out;
  logic [3:0]  flags;

  logic        h_in_valid = 1'b0, h_sub = 1'b0, h_out_ready = 1'b1;
  logic        h_in_ready, h_out_valid;
  logic [15:0] h_a = '0, h_b = '0, h_out;
  logic [3:0]  h_flags;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags(flags)
  );

  fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .sub(h_sub), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out(h_out), .flags(h_flags)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          id;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, stall_lo = -1, stall_hi = -1;
  int          n_in = 0, n_out = 0, n_disc = 0, op_id = 0;
  bit          chk_lat = 1'b1, accepted = 1'b0;
  logic [31:0] cur_res = '0;
  logic [3:0]  cur_fl = '0;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, expv);
    end
  endtask

  task automatic checkint(input string tag, input int got, input int expv);
    checks++;
    assert (got == expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // One clock of the main DUT: handshake bookkeeping before the edge.
  task automatic cycle();
    exp_t e;
    bit   stalled;
    stalled   = (cyc >= stall_lo) && (cyc <= stall_hi);
    out_ready = !stalled;
    #1;
    if (stalled) begin
      check1("stall out_valid", out_valid, 1'b1);
      check1("stall in_ready", in_ready, 1'b0);
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      e.res = cur_res; e.fl = cur_fl; e.id = op_id; e.cyc = cyc;
      sb_q.push_back(e);
      n_in++;
    end
    if (out_valid) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected output: got %h expected none", out);
      end
      if (sb_q.size() != 0) begin
        if (out_ready) begin
          e = sb_q.pop_front();
          n_out++;
          check32($sformatf("op%0d out", e.id), out, e.res);
          check32($sformatf("op%0d flags", e.id), 32'(flags), 32'(e.fl));
          if (chk_lat) checkint($sformatf("op%0d latency", e.id), cyc - e.cyc, 3);
        end else begin
          check32("held out", out, sb_q[0].res);
          check32("held flags", 32'(flags), 32'(sb_q[0].fl));
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                       input logic [31:0] r, input logic [3:0] f);
    a = ia; b = ib; sub = isub; cur_res = r; cur_fl = f;
    in_valid = 1'b1;
    op_id++;
    accepted = 1'b0;
    for (int k = 0; k < 20 && !accepted; k++) cycle();
    check1("issue accepted", accepted, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb_q.size() != 0; k++) cycle();
    checkint("drain queue empty", sb_q.size(), 0);
  endtask

  task automatic half_op(input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] r, input logic [3:0] f);
    h_a = ia; h_b = ib; h_sub = 1'b0; h_in_valid = 1'b1;
    #1;
    check1("half in_ready", h_in_ready, 1'b1);
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    @(posedge clk); #1;
    check1("half out_valid early", h_out_valid, 1'b0);
    @(posedge clk); #1;
    check1("half out_valid", h_out_valid, 1'b1);
    check32("half out", 32'(h_out), 32'(r));
    check32("half flags", 32'(h_flags), 32'(f));
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    #8;
    check1("reset out_valid", out_valid, 1'b0);
    check32("reset out", out, 32'h0);
    check32("reset flags", 32'(flags), 32'h0);
    rst = 1'b0;
    #1;
    check1("in_ready after reset", in_ready, 1'b1);
    @(posedge clk); #1;

    // Back-to-back directed operations, latency checked
    cyc = 0; chk_lat = 1'b1;
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0);
    issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0);
    issue(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0);
    issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1);
    issue(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1);
    issue(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5);
    issue(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8);
    issue(32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'h0);
    issue(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8);
    issue(32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 4'h0);
    issue(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0);
    issue(32'h80000000, 32'hC0000000, 1'b0, 32'hC0000000, 4'h0);
    issue(32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 4'h0);
    issue(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0);
    issue(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'h3);
    issue(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'h1);
    issue(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'h1);
    drain();

    // Back-pressure: out_ready low in burst cycles 4..6
    cyc = 0; chk_lat = 1'b0; stall_lo = 4; stall_hi = 6;
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0);
    issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0);
    issue(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0);
    issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1);
    issue(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1);
    drain();
    stall_lo = -1; stall_hi = -1;
    checkint("stall burst length", cyc >= 10 ? 1 : 0, 1);

    // Reset with operations in flight
    cyc = 0; chk_lat = 1'b1;
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5);
    rst = 1'b1;
    #1;
    check1("mid reset out_valid", out_valid, 1'b0);
    check32("mid reset out", out, 32'h0);
    #1;
    rst = 1'b0;
    n_disc += sb_q.size();
    sb_q.delete();
    #1;
    check1("in_ready after mid reset", in_ready, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check1("no stale output", out_valid, 1'b0);
    end
    cyc = 0;
    issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0);
    drain();
    checkint("ops accounted", n_out + n_disc, n_in);

    // Half-precision instance
    half_op(16'h3C00, 16'h3C00, 16'h4000, 4'h0);
    half_op(16'h7BFF, 16'h7BFF, 16'h7C00, 4'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
